pci_tgt_seq: RTL and testbench

Target-side transaction sequencer between the PCI core's user-app target interface and the backend BAR memories. It decodes base_hit and pci_cmd and inserts the programmed wait states. It then drives s_ready, s_term and s_abort, and generates per-beat read/write strobes plus an incrementing word address. It also forces a disconnect when a burst reaches its length limit.

---
 rtl/pci_tgt_seq.sv | 209 ++++++++++++++++++++
 tb/tb_pci_tgt_seq.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_tgt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pci_tgt_seq
//  Description : PCI target transaction sequencer. Decodes the BAR hit and
//                command of an address phase, inserts programmed wait states,
//                drives s_ready/s_term/s_abort back to the core and produces
//                per-beat backend strobes with an incrementing word address.
//                Bursts are disconnected once MAX_BURST beats have moved.
//  Revision    : 1.0  initial release
// ============================================================================
module pci_tgt_seq #(
    parameter int         AW          = 10,      // backend word-address width
    parameter int         WAIT_STATES = 2,       // 0..15 target wait cycles
    parameter int         MAX_BURST   = 16,      // 2..256 beats per burst
    parameter logic [7:0] BAR_MASK    = 8'h07    // BARs served by this target
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic [7:0]    base_hit,
    input  logic          addr_vld,
    input  logic [31:0]   addr,
    input  logic [15:0]   pci_cmd,
    input  logic          s_wrdn,
    input  logic          s_data,
    input  logic          s_data_vld,
    input  logic          bk_ready,
    output logic          s_ready,
    output logic          s_term,
    output logic          s_abort,
    output logic [7:0]    bar_sel,
    output logic [AW-1:0] word_addr,
    output logic          wr_en,
    output logic          rd_en
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Memory read (6), memory write (7), read multiple (12), read line (14).
    localparam logic [15:0] c_CMD_SUPPORTED = 16'h50C0;
    localparam int          c_BW            = $clog2(MAX_BURST) + 1;
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(MAX_BURST - 1);
    localparam logic [3:0]  c_WAIT_LOAD     = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_XFER  = 3'd2,
        ST_TERM  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;

    logic [3:0]      r_wait_cnt;
    logic [c_BW-1:0] r_beat_cnt;
    logic            r_dir;          // 1 = write transaction
    logic [7:0]      r_bar_sel;
    logic [AW-1:0]   r_word_addr;
    logic            r_s_ready;
    logic            r_s_term;
    logic            r_s_abort;

    logic            w_accept;       // address phase taken this cycle
    logic            w_cmd_ok;
    logic            w_bad_req;      // must be target-aborted
    logic            w_beat;         // data beat moved this cycle
    logic            w_last_beat;
    logic            w_dir_nxt;
    logic            w_prefetch;     // first read fetch on entering XFER
    logic            w_unused_addr;

    // Address bits outside the word-address window do not affect the backend.
    assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    // A command is served only if it is non-empty and uses supported bits alone.
    assign w_cmd_ok    = (pci_cmd != 16'h0000) &&
                         ((pci_cmd & ~c_CMD_SUPPORTED) == 16'h0000);
    assign w_bad_req   = ((base_hit & ~BAR_MASK) != 8'h00) || !w_cmd_ok;
    assign w_accept    = (r_state == ST_IDLE) && addr_vld && (base_hit != 8'h00);
    assign w_beat      = (r_state == ST_XFER) && s_data_vld;
    assign w_last_beat = (r_beat_cnt == c_LAST_BEAT);

    // Direction as it will be once the current cycle completes; needed so a
    // zero-wait read still prefetches on the IDLE->XFER edge.
    assign w_dir_nxt   = w_accept ? s_wrdn : r_dir;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Sequence IDLE -> (WAIT) -> XFER -> (TERM) -> IDLE, or IDLE -> ABORT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_bad_req) begin
                        w_state_nxt = ST_ABORT;
                    end else if (WAIT_STATES == 0) begin
                        w_state_nxt = ST_XFER;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // The counter reaches zero on this cycle when it reads 1; once
                // at zero it parks there until the backend is ready.
                if ((r_wait_cnt <= 4'd1) && bk_ready) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                // Master completion wins over the burst limit.
                if (!s_data) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_beat && w_last_beat) begin
                    w_state_nxt = ST_TERM;
                end
            end
            ST_TERM: begin
                if (!s_data) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (!s_data) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and core-handshake registers
    // ------------------------------------------------------------------------
    // Handshake outputs are derived from the next state so they change on the
    // same edge as the state that causes them.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_s_term  <= 1'b0;
            r_s_abort <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt == ST_XFER) && bk_ready;
            r_s_term  <= (w_state_nxt == ST_TERM);
            r_s_abort <= (w_state_nxt == ST_ABORT);
        end
    end

    // ------------------------------------------------------------------------
    // Transaction context: BAR, direction, word address, wait and beat counts
    // ------------------------------------------------------------------------
    // Latched on an accepted address phase, then advanced by wait cycles and
    // data beats; nothing moves in ABORT or TERM.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_bar_sel   <= 8'h00;
            r_dir       <= 1'b0;
            r_word_addr <= '0;
            r_wait_cnt  <= 4'd0;
            r_beat_cnt  <= '0;
        end else if (w_accept) begin
            r_bar_sel   <= base_hit;
            r_dir       <= s_wrdn;
            r_word_addr <= addr[AW+1:2];
            r_wait_cnt  <= c_WAIT_LOAD;
            r_beat_cnt  <= '0;
        end else begin
            if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_beat) begin
                r_word_addr <= r_word_addr + AW'(1);
                r_beat_cnt  <= r_beat_cnt + c_BW'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Backend strobes
    // ------------------------------------------------------------------------
    // A read fetches the first word while entering XFER so data is waiting
    // when s_ready rises; each read beat then advances to the next word.
    assign w_prefetch = (r_state != ST_XFER) && (w_state_nxt == ST_XFER) && !w_dir_nxt;

    assign wr_en     = w_beat && r_dir;
    assign rd_en     = (w_beat && !r_dir) || w_prefetch;

    assign s_ready   = r_s_ready;
    assign s_term    = r_s_term;
    assign s_abort   = r_s_abort;
    assign bar_sel   = r_bar_sel;
    assign word_addr = r_word_addr;

endmodule
`default_nettype wire

// File: tb/tb_pci_tgt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pci_tgt_seq
//  Description : Directed self-checking bench for pci_tgt_seq. A second
//                instance with AW=4 shares the stimulus to exercise address
//                wrap in a narrow backend.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pci_tgt_seq;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic [7:0]  base_hit;
    logic        addr_vld;
    logic [31:0] addr;
    logic [15:0] pci_cmd;
    logic        s_wrdn;
    logic        s_data;
    logic        s_data_vld;
    logic        bk_ready;

    logic        s_ready;
    logic        s_term;
    logic        s_abort;
    logic [7:0]  bar_sel;
    logic [9:0]  word_addr;
    logic        wr_en;
    logic        rd_en;

    logic        n4_unused_ready;
    logic        n4_unused_term;
    logic        n4_unused_abort;
    logic [7:0]  n4_unused_bar;
    logic [3:0]  word_addr4;
    logic        wr_en4;
    logic        n4_unused_rd;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] wr_q[$];
    logic [9:0] rd_q[$];
    logic [3:0] wr4_q[$];
    int         n_term_cyc;
    int         n_abort_cyc;

    int   m_lat;
    int   m_stall;
    int   m_term_cyc;
    int   m_term_done;
    int   m_last_beat;
    logic m_term_rdy;

    pci_tgt_seq #(
        .AW(10), .WAIT_STATES(2), .MAX_BURST(16), .BAR_MASK(8'h07)
    ) u_dut (
        .CLK(CLK), .reset_n(reset_n), .base_hit(base_hit), .addr_vld(addr_vld),
        .addr(addr), .pci_cmd(pci_cmd), .s_wrdn(s_wrdn), .s_data(s_data),
        .s_data_vld(s_data_vld), .bk_ready(bk_ready), .s_ready(s_ready),
        .s_term(s_term), .s_abort(s_abort), .bar_sel(bar_sel),
        .word_addr(word_addr), .wr_en(wr_en), .rd_en(rd_en)
    );

    pci_tgt_seq #(
        .AW(4), .WAIT_STATES(2), .MAX_BURST(16), .BAR_MASK(8'h07)
    ) u_dut_aw4 (
        .CLK(CLK), .reset_n(reset_n), .base_hit(base_hit), .addr_vld(addr_vld),
        .addr(addr), .pci_cmd(pci_cmd), .s_wrdn(s_wrdn), .s_data(s_data),
        .s_data_vld(s_data_vld), .bk_ready(bk_ready), .s_ready(n4_unused_ready),
        .s_term(n4_unused_term), .s_abort(n4_unused_abort), .bar_sel(n4_unused_bar),
        .word_addr(word_addr4), .wr_en(wr_en4), .rd_en(n4_unused_rd)
    );

    always #5 CLK = ~CLK;

    // Record backend strobes and handshake activity mid-cycle.
    always @(negedge CLK) begin
        if (reset_n) begin
            if (wr_en)  wr_q.push_back(word_addr);
            if (rd_en)  rd_q.push_back(word_addr);
            if (wr_en4) wr4_q.push_back(word_addr4);
            if (s_term)  n_term_cyc++;
            if (s_abort) n_abort_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        wr4_q.delete();
        n_term_cyc  = 0;
        n_abort_cyc = 0;
    endtask

    // PCI master plus backend model: one address phase, then beats whenever
    // s_ready is seen, ending after nbeats or on s_term/s_abort. The backend
    // drops bk_ready for drop_n cycles once drop_at beats have completed.
    task automatic master(input logic [7:0] bh, input logic [15:0] cmd,
                          input logic [31:0] a, input logic wr, input int nbeats,
                          input int drop_at, input int drop_n);
        int done = 0;
        int cyc  = 0;
        int left = drop_n;
        m_lat = -1; m_stall = 0; m_term_cyc = -1; m_term_done = -1;
        m_last_beat = -1; m_term_rdy = 1'bx;
        base_hit = bh; pci_cmd = cmd; addr = a; s_wrdn = wr;
        addr_vld = 1'b1; s_data = 1'b1; s_data_vld = 1'b0; bk_ready = 1'b1;
        tick();
        addr_vld = 1'b0; base_hit = 8'h00;
        cyc = 1;
        while (s_data && cyc < 200) begin
            if (s_ready && m_lat < 0) m_lat = cyc;
            if (s_term && m_term_cyc < 0) begin
                m_term_cyc = cyc; m_term_done = done; m_term_rdy = s_ready;
            end
            if (m_lat >= 0 && !s_ready && done < nbeats && !s_term && !s_abort) m_stall++;
            if (left > 0 && done >= drop_at) begin
                bk_ready = 1'b0; left--;
            end else begin
                bk_ready = 1'b1;
            end
            if (s_term || s_abort || done >= nbeats) begin
                s_data_vld = 1'b0; s_data = 1'b0;
            end else if (s_ready) begin
                s_data_vld = 1'b1; done++; m_last_beat = cyc;
            end else begin
                s_data_vld = 1'b0;
            end
            tick();
            cyc++;
        end
        chk("master_in_budget", 32'(cyc < 200), 32'd1);
        s_data = 1'b0; s_data_vld = 1'b0; bk_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; base_hit = 8'h00; addr_vld = 1'b0; addr = 32'h0;
        pci_cmd = 16'h0; s_wrdn = 1'b0; s_data = 1'b0; s_data_vld = 1'b0; bk_ready = 1'b1;
        clear_mon();
        repeat (3) tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_term", s_term, 0);
        chk("rst_abort", s_abort, 0);
        chk("rst_bar", bar_sel, 0);
        chk("rst_waddr", word_addr, 0);
        chk("rst_wr", wr_en, 0);
        chk("rst_rd", rd_en, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // 1: single write, two wait states
        clear_mon();
        master(8'h01, 16'h0080, 32'h0000_0010, 1'b1, 1, 1000, 0);
        chk("t1_latency", m_lat, 3);
        chk("t1_wr_count", wr_q.size(), 1);
        if (wr_q.size() == 1) chk("t1_wr_addr", wr_q[0], 4);
        chk("t1_rd_count", rd_q.size(), 0);
        chk("t1_no_term", n_term_cyc, 0);
        chk("t1_no_abort", n_abort_cyc, 0);
        chk("t1_idle_ready", s_ready, 0);
        chk("t1_bar", bar_sel, 8'h01);
        chk("t1_waddr_end", word_addr, 5);
        tick();

        // 2: read burst of 4 with first-word prefetch
        clear_mon();
        master(8'h02, 16'h1000, 32'h0000_0010, 1'b0, 4, 1000, 0);
        chk("t2_latency", m_lat, 3);
        chk("t2_rd_count", rd_q.size(), 5);
        if (rd_q.size() == 5) begin
            chk("t2_rd0_prefetch", rd_q[0], 4);
            chk("t2_rd1", rd_q[1], 4);
            chk("t2_rd2", rd_q[2], 5);
            chk("t2_rd3", rd_q[3], 6);
            chk("t2_rd4", rd_q[4], 7);
        end
        chk("t2_wr_count", wr_q.size(), 0);
        chk("t2_no_term", n_term_cyc, 0);
        chk("t2_waddr_end", word_addr, 8);
        chk("t2_bar", bar_sel, 8'h02);
        tick();

        // address phase without a BAR hit is ignored
        addr_vld = 1'b1; base_hit = 8'h00; addr = 32'h0000_0300;
        pci_cmd = 16'h0080; s_wrdn = 1'b1; s_data = 1'b1;
        tick();
        addr_vld = 1'b0;
        tick();
        chk("nohit_ready", s_ready, 0);
        chk("nohit_abort", s_abort, 0);
        chk("nohit_bar", bar_sel, 8'h02);
        chk("nohit_waddr", word_addr, 8);
        s_data = 1'b0;
        tick();

        // 3: master streams 20 writes, target disconnects after 16
        clear_mon();
        master(8'h04, 16'h0080, 32'h0000_0100, 1'b1, 20, 1000, 0);
        chk("t3_wr_count", wr_q.size(), 16);
        if (wr_q.size() == 16) begin
            chk("t3_wr_first", wr_q[0], 64);
            chk("t3_wr_last", wr_q[15], 79);
        end
        chk("t3_term_after_16", m_term_done, 16);
        chk("t3_term_ready_low", m_term_rdy, 0);
        chk("t3_term_next_cycle", m_term_cyc - m_last_beat, 1);
        chk("t3_term_cycles", n_term_cyc, 1);
        chk("t3_term_cleared", s_term, 0);
        chk("t3_waddr_end", word_addr, 80);
        tick();

        // 4a: hit on an unserved BAR
        clear_mon();
        base_hit = 8'h10; pci_cmd = 16'h0080; addr = 32'h0000_0040; s_wrdn = 1'b1;
        addr_vld = 1'b1; s_data = 1'b1; s_data_vld = 1'b0;
        tick();
        chk("t4a_abort", s_abort, 1);
        chk("t4a_ready", s_ready, 0);
        chk("t4a_bar", bar_sel, 8'h10);
        // master keeps signalling beats and a stray address phase arrives
        addr_vld = 1'b1; base_hit = 8'h04; s_data_vld = 1'b1;
        tick();
        addr_vld = 1'b0; base_hit = 8'h00;
        chk("t4a_abort_hold", s_abort, 1);
        chk("t4a_bar_hold", bar_sel, 8'h10);
        s_data = 1'b0; s_data_vld = 1'b0;
        tick();
        chk("t4a_release", s_abort, 0);
        chk("t4a_no_wr", wr_q.size(), 0);
        chk("t4a_no_rd", rd_q.size(), 0);
        chk("t4a_abort_cycles", n_abort_cyc, 2);
        chk("t4a_waddr_frozen", word_addr, 16);
        chk("t4a_term", n_term_cyc, 0);
        tick();

        // 4b: unsupported command on a served BAR
        clear_mon();
        base_hit = 8'h01; pci_cmd = 16'h0004; addr = 32'h0000_0080; s_wrdn = 1'b0;
        addr_vld = 1'b1; s_data = 1'b1;
        tick();
        addr_vld = 1'b0; base_hit = 8'h00;
        chk("t4b_abort", s_abort, 1);
        chk("t4b_ready", s_ready, 0);
        s_data = 1'b0;
        tick();
        chk("t4b_release", s_abort, 0);
        chk("t4b_no_rd", rd_q.size(), 0);
        chk("t4b_bar", bar_sel, 8'h01);
        tick();

        // 5: backpressure mid-burst with address wrap in both instances
        clear_mon();
        master(8'h01, 16'h0080, 32'h0000_0FF8, 1'b1, 4, 2, 3);
        chk("t5_stall_cycles", m_stall, 3);
        chk("t5_wr_count", wr_q.size(), 4);
        chk("t5_wr4_count", wr4_q.size(), 4);
        if (wr_q.size() == 4) begin
            chk("t5_a0", wr_q[0], 1022);
            chk("t5_a1", wr_q[1], 1023);
            chk("t5_a2", wr_q[2], 0);
            chk("t5_a3", wr_q[3], 1);
        end
        if (wr4_q.size() == 4) begin
            chk("t5_aw4_a0", wr4_q[0], 14);
            chk("t5_aw4_a1", wr4_q[1], 15);
            chk("t5_aw4_a2", wr4_q[2], 0);
            chk("t5_aw4_a3", wr4_q[3], 1);
        end
        tick();

        // 6: asynchronous reset in the middle of a write burst
        clear_mon();
        base_hit = 8'h01; pci_cmd = 16'h0080; addr = 32'h0000_0020; s_wrdn = 1'b1;
        addr_vld = 1'b1; s_data = 1'b1; s_data_vld = 1'b0; bk_ready = 1'b1;
        tick();
        addr_vld = 1'b0; base_hit = 8'h00;
        for (int i = 0; i < 10 && !s_ready; i++) tick();
        chk("t6_ready_seen", s_ready, 1);
        s_data_vld = 1'b1;
        tick();
        tick();
        #2;
        chk("t6_pre_rst_wr", wr_en, 1);
        chk("t6_pre_rst_waddr", word_addr, 10);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_ready", s_ready, 0);
        chk("t6_rst_wr", wr_en, 0);
        chk("t6_rst_waddr", word_addr, 0);
        chk("t6_rst_bar", bar_sel, 0);
        chk("t6_rst_term", s_term, 0);
        chk("t6_rst_abort", s_abort, 0);
        s_data = 1'b0; s_data_vld = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        clear_mon();
        master(8'h02, 16'h0080, 32'h0000_0040, 1'b1, 1, 1000, 0);
        chk("t6_after_latency", m_lat, 3);
        chk("t6_after_wr_count", wr_q.size(), 1);
        if (wr_q.size() == 1) chk("t6_after_wr_addr", wr_q[0], 16);
        chk("t6_after_bar", bar_sel, 8'h02);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
